// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-port (cpu/dma) memory-space bus cycle sequencer with round-robin arbitration
module mem_bus_arbiter #(
    parameter int RAM_WS   = 1,
    parameter int ROM_WS   = 2,
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [23:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [23:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic        dma_ack,
    output logic [15:0] rdata,
    output logic [23:0] ab,
    output logic [15:0] db_out,
    output logic        db_oe,
    input  logic [15:0] db_in,
    input  logic        nws,
    output logic        nmem,
    output logic        nr,
    output logic        nw,
    output logic        grant,
    output logic        err
);

    localparam logic [7:0] LP_RAM_WS   = 8'(RAM_WS);
    localparam logic [7:0] LP_ROM_WS   = 8'(ROM_WS);
    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [23:0] r_addr;
    logic        r_we;
    logic [15:0] r_wdata;
    logic        r_grant;
    logic        r_last_dma;
    logic [7:0]  r_wait;
    logic [7:0]  r_stretch;
    logic        r_timeout;
    logic [15:0] r_rdata;

    logic w_start;
    logic w_pick_dma;
    logic w_rom;
    logic w_busy;
    logic w_wait_done;
    logic w_timeout_hit;

    // On a tie the port not served last wins; a lone requester always wins.
    assign w_start       = cpu_req | dma_req;
    assign w_pick_dma    = dma_req & (~cpu_req | ~r_last_dma);
    assign w_rom         = (r_addr[23:22] == 2'b10);
    assign w_busy        = (r_state != ST_IDLE);
    assign w_wait_done   = (r_wait == 8'd0);
    assign w_timeout_hit = (r_stretch == LP_MAX_WAIT);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_start) w_next = ST_SETUP;
            ST_SETUP:  w_next = ST_STROBE;
            ST_STROBE: if (w_wait_done && (w_timeout_hit || nws)) w_next = ST_HOLD;
            ST_HOLD:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_addr     <= 24'd0;
            r_we       <= 1'b0;
            r_wdata    <= 16'd0;
            r_grant    <= 1'b0;
            r_last_dma <= 1'b1;
            r_wait     <= 8'd0;
            r_stretch  <= 8'd0;
            r_timeout  <= 1'b0;
            r_rdata    <= 16'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_addr     <= w_pick_dma ? dma_addr  : cpu_addr;
                        r_we       <= w_pick_dma ? dma_we    : cpu_we;
                        r_wdata    <= w_pick_dma ? dma_wdata : cpu_wdata;
                        r_grant    <= w_pick_dma;
                        r_last_dma <= w_pick_dma;
                        r_stretch  <= 8'd0;
                        r_timeout  <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    r_wait <= w_rom ? LP_ROM_WS : LP_RAM_WS;
                end
                ST_STROBE: begin
                    // Programmed wait states run first; nws only stretches once they expire.
                    if (!w_wait_done) begin
                        r_wait <= r_wait - 8'd1;
                    end else if (w_timeout_hit) begin
                        r_timeout <= 1'b1;
                        if (!r_we) r_rdata <= 16'hFFFF;
                    end else if (nws) begin
                        if (!r_we) r_rdata <= db_in;
                    end else begin
                        r_stretch <= r_stretch + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes decode straight from state so an async reset releases the bus at once.
    assign nmem    = ~w_busy;
    assign nr      = ~((r_state == ST_STROBE) & ~r_we);
    assign nw      = ~((r_state == ST_STROBE) & r_we & ~w_rom);
    assign db_oe   = w_busy & r_we;
    assign ab      = r_addr;
    assign db_out  = r_wdata;
    assign rdata   = r_rdata;
    assign grant   = r_grant;
    assign cpu_ack = (r_state == ST_HOLD) & ~r_grant;
    assign dma_ack = (r_state == ST_HOLD) &  r_grant;
    assign err     = (r_state == ST_HOLD) & (r_timeout | (r_we & w_rom));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [23:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        dma_req, dma_we, dma_ack;
    logic [23:0] dma_addr;
    logic [15:0] dma_wdata;
    logic [15:0] rdata, db_out, db_in;
    logic [23:0] ab;
    logic        db_oe, nws, nmem, nr, nw, grant, err;

    int n_total = 0;
    int n_pass  = 0;
    int n_inv   = 0;
    logic prev_nmem = 1'b1;

    logic [31:0] m_nmem, m_nr, m_nw, m_oe, m_cack, m_dack, m_err;
    logic [7:0]  gseq;
    logic [15:0] ack_rdata, ack_dbout;

    mem_bus_arbiter #(.RAM_WS(1), .ROM_WS(2), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
        .rdata(rdata), .ab(ab), .db_out(db_out), .db_oe(db_oe), .db_in(db_in), .nws(nws),
        .nmem(nmem), .nr(nr), .nw(nw), .grant(grant), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (!nr && !nw) n_inv++;
            if ((!nr || !nw) && prev_nmem) n_inv++;
        end
        prev_nmem = nmem;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Cycle 0 is the current IDLE cycle; cycle c is sampled at the negedge after the c-th edge.
    task automatic run(input int ncyc, input int ncpu, input int ndma, input logic [31:0] nws_low);
        int c_left, d_left;
        c_left = ncpu;
        d_left = ndma;
        m_nmem = 0; m_nr = 0; m_nw = 0; m_oe = 0; m_cack = 0; m_dack = 0; m_err = 0;
        gseq = 0; ack_rdata = 16'h0; ack_dbout = 16'h0;
        cpu_req = (ncpu > 0);
        dma_req = (ndma > 0);
        nws = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            m_nmem[c] = ~nmem;
            m_nr[c]   = ~nr;
            m_nw[c]   = ~nw;
            m_oe[c]   = db_oe;
            m_cack[c] = cpu_ack;
            m_dack[c] = dma_ack;
            m_err[c]  = err;
            if (cpu_ack || dma_ack) begin
                gseq = {gseq[6:0], grant};
                ack_rdata = rdata;
                ack_dbout = db_out;
            end
            if (cpu_ack) begin
                c_left--;
                if (c_left <= 0) cpu_req = 1'b0;
            end
            if (dma_ack) begin
                d_left--;
                if (d_left <= 0) dma_req = 1'b0;
            end
            nws = ~nws_low[c];
        end
        nws = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        db_in = 0; nws = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_nmem", nmem, 1);
        chk("rst_nr", nr, 1);
        chk("rst_nw", nw, 1);
        chk("rst_oe", db_oe, 0);
        chk("rst_ab", ab, 0);
        chk("rst_dbout", db_out, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_acks", {cpu_ack, dma_ack, err}, 0);
        chk("rst_grant", grant, 0);
        reset = 1'b0;

        cpu_addr = 24'h000010; cpu_we = 0; db_in = 16'hA5C3;
        run(8, 1, 0, 0);
        chk("t1_nmem", m_nmem, 32'h1E);
        chk("t1_nr", m_nr, 32'h0C);
        chk("t1_nw", m_nw, 0);
        chk("t1_cack", m_cack, 32'h10);
        chk("t1_dack", m_dack, 0);
        chk("t1_rdata", ack_rdata, 16'hA5C3);
        chk("t1_ab", ab, 24'h000010);

        dma_addr = 24'h000200; dma_we = 1; dma_wdata = 16'h1234; db_in = 16'h0;
        run(8, 0, 1, 0);
        chk("t2_nmem", m_nmem, 32'h1E);
        chk("t2_nw", m_nw, 32'h0C);
        chk("t2_nr", m_nr, 0);
        chk("t2_oe", m_oe, 32'h1E);
        chk("t2_dbout", ack_dbout, 16'h1234);
        chk("t2_dack", m_dack, 32'h10);
        chk("t2_cack", m_cack, 0);
        chk("t2_grant", gseq, 8'h01);
        chk("t2_rdata_kept", rdata, 16'hA5C3);

        cpu_addr = 24'h000020; cpu_we = 0; db_in = 16'h1111;
        dma_addr = 24'h000030; dma_we = 0;
        run(31, 3, 3, 0);
        chk("t3_gseq", gseq, 8'b0001_0101);
        chk("t3_cack", m_cack, 32'h0100_4010);
        chk("t3_dack", m_dack, 32'h2008_0200);

        cpu_addr = 24'h800000; cpu_we = 0; db_in = 16'h5A5A;
        run(8, 1, 0, 0);
        chk("t4_nr", m_nr, 32'h1C);
        chk("t4_nmem", m_nmem, 32'h3E);
        chk("t4_cack", m_cack, 32'h20);
        chk("t4_err", m_err, 0);
        chk("t4_rdata", ack_rdata, 16'h5A5A);

        dma_addr = 24'h800000; dma_we = 1; dma_wdata = 16'hBEEF;
        run(8, 0, 1, 0);
        chk("t5_nw", m_nw, 0);
        chk("t5_dack", m_dack, 32'h20);
        chk("t5_err", m_err, 32'h20);

        cpu_addr = 24'h000040; cpu_we = 0; db_in = 16'h2222;
        run(12, 1, 0, 32'hFFFF_FFFE);
        chk("t6_nr", m_nr, 32'hFC);
        chk("t6_cack", m_cack, 32'h100);
        chk("t6_err", m_err, 32'h100);
        chk("t6_rdata", ack_rdata, 16'hFFFF);

        db_in = 16'h0F0F;
        run(10, 1, 0, 32'h18);
        chk("t7_nr", m_nr, 32'h3C);
        chk("t7_cack", m_cack, 32'h40);
        chk("t7_err", m_err, 0);
        chk("t7_rdata", ack_rdata, 16'h0F0F);

        cpu_addr = 24'h000300; cpu_we = 1; cpu_wdata = 16'h7777;
        dma_addr = 24'h000400; dma_we = 1; dma_wdata = 16'h8888;
        cpu_req = 1; dma_req = 1;
        @(negedge clk);
        @(negedge clk);
        chk("t8_strobe_nw", nw, 0);
        chk("t8_strobe_oe", db_oe, 1);
        #2 reset = 1'b1;
        #1;
        chk("t8_rst_nw", nw, 1);
        chk("t8_rst_nmem", nmem, 1);
        chk("t8_rst_oe", db_oe, 0);
        @(negedge clk);
        chk("t8_rst_noack", {cpu_ack, dma_ack}, 0);
        reset = 1'b0;
        run(12, 1, 1, 0);
        chk("t8_cack", m_cack, 32'h10);
        chk("t8_dack", m_dack, 32'h200);
        chk("t8_gseq", gseq, 8'b01);
        chk("t8_nw", m_nw, 32'h18C);

        chk("strobe_invariants", n_inv, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
